// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// Main entry M drives the output; skid entry S absorbs the one extra word
// that can arrive while in_ready (registered) is still high.
// Adds flush and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W     = 128,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   m_q, m_d;
  logic [DATA_W-1:0]   s_q, s_d;
  logic                in_ready_q, in_ready_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    bubble_q, bubble_d;
  logic                in_fire, out_fire;

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = out_valid ? m_q : BUBBLE_VAL;
  assign occupancy  = state_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign in_fire    = in_valid & in_ready_q;
  assign out_fire   = out_valid & out_ready;

  // Next-state, storage updates and registered ready.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          m_d     = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          m_d = in_data;
        end else if (in_fire) begin
          s_d     = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops both entries and any word offered this cycle; a word
    // taken downstream in the same cycle is already consumed.
    if (flush) state_d = EMPTY;
    // in_ready is a flop, so it is derived from where the stage will be.
    in_ready_d = (state_d != FULL);
  end

  // Saturating performance counters; flush does not touch them.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
    if (!out_valid && out_ready && (bubble_q != '1))
      bubble_d = bubble_q + CNT_W'(1);
  end

  // State, storage and counter registers; synchronous reset wins over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      m_q        <= BUBBLE_VAL;
      s_q        <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, counter saturation
// sequences, then random traffic against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_skid #(
    .DATA_W    (DW),
    .BUBBLE_VAL(32'h0),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a FIFO of at most two words plus two capped counters.
  logic [DW-1:0] mq[$];
  int unsigned   m_stall  = 0;
  int unsigned   m_bubble = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input bit rst, input bit fl, input bit iv,
                      input logic [DW-1:0] id, input bit ordy);
    bit m_in_fire, m_out_fire;
    reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (mq.size() > 0 && !ordy && m_stall < CMAX) m_stall++;
      if (mq.size() == 0 && ordy && m_bubble < CMAX) m_bubble++;
      m_in_fire  = iv && (mq.size() < 2);
      m_out_fire = (mq.size() > 0) && ordy;
      if (fl) mq.delete();
      else begin
        if (m_out_fire) void'(mq.pop_front());
        if (m_in_fire) mq.push_back(id);
      end
    end
    #1;
    chk("out_valid",  64'(out_valid),  64'(mq.size() > 0));
    chk("out_data",   64'(out_data),   64'((mq.size() > 0) ? mq[0] : '0));
    chk("in_ready",   64'(in_ready),   64'(mq.size() < 2));
    chk("occupancy",  64'(occupancy),  64'(mq.size()));
    chk("stall_cnt",  64'(stall_cnt),  64'(m_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
  endtask

  typedef struct {
    bit            rst, fl, iv;
    logic [DW-1:0] id;
    bit            ordy;
    bit            ov;
    logic [DW-1:0] od;
    bit            ir;
    logic [1:0]    occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit fl, bit iv, logic [DW-1:0] id, bit ordy,
                              bit ov, logic [DW-1:0] od, bit ir, logic [1:0] occ);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
    return v;
  endfunction

  initial begin
    // Reset held two cycles with a word offered.
    tbl.push_back(mk(1, 0, 1, 32'h99, 0,  0, 32'h0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h99, 0,  0, 32'h0, 1, 0));
    // Back-to-back stream 1..8 with downstream always ready.
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0, 0, 1, DW'(k), 1,  1, DW'(k), 1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0, 1,  0, 32'h0, 1, 0));
    // Backpressure: A held, B to skid, C refused, then drain in order.
    tbl.push_back(mk(0, 0, 1, 32'hA, 0,  1, 32'hA, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'hB, 0,  1, 32'hA, 0, 2));
    tbl.push_back(mk(0, 0, 1, 32'hC, 0,  1, 32'hA, 0, 2));
    tbl.push_back(mk(0, 0, 1, 32'hC, 1,  1, 32'hB, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'hC, 1,  1, 32'hC, 1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0, 1,  0, 32'h0, 1, 0));
    // Fill, then flush with a word offered: nothing survives.
    tbl.push_back(mk(0, 0, 1, 32'h11, 0,  1, 32'h11, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h22, 0,  1, 32'h11, 0, 2));
    tbl.push_back(mk(0, 1, 1, 32'hDEAD, 0,  0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0,  0, 32'h0, 1, 0));
    // Simultaneous in/out fire in ONE, then the same with reset.
    tbl.push_back(mk(0, 0, 1, 32'h44, 0,  1, 32'h44, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h55, 1,  1, 32'h55, 1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h66, 1,  0, 32'h0, 1, 0));
    tbl[tbl.size()-1].rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d.out_data", i),  64'(out_data),  64'(tbl[i].od));
      chk($sformatf("vec%0d.in_ready", i),  64'(in_ready),  64'(tbl[i].ir));
      chk($sformatf("vec%0d.occupancy", i), 64'(occupancy), 64'(tbl[i].occ));
    end
    chk("reset_clears_bubble", 64'(bubble_cnt), 64'h0);
    chk("reset_clears_stall",  64'(stall_cnt),  64'h0);

    // Bubble counter saturates and survives a flush.
    for (int k = 0; k < 20; k++) step(0, 0, 0, '0, 1);
    chk("bubble_sat", 64'(bubble_cnt), 64'd15);
    step(0, 1, 0, '0, 1);
    chk("bubble_after_flush", 64'(bubble_cnt), 64'd15);

    // Stall counter saturates while a word is held.
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 32'h77, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, '0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'd15);
    chk("stall_hold_data", 64'(out_data), 64'h77);

    // Random traffic; counters are reset periodically so they stay live.
    for (int k = 0; k < 3000; k++) begin
      bit rst, fl, iv, ordy;
      rst  = ($urandom_range(0, 99) < 2);
      fl   = ($urandom_range(0, 99) < 6);
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < ((k / 200) % 2 == 0 ? 40 : 85));
      step(rst, fl, iv, $urandom, ordy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
